// File: rtl/pulse_meter_if.sv
// Result stream from pulse_meter toward capture/readout: tagged pulse widths with valid/ready handshake.
interface pulse_meter_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_width;
    logic [CW-1:0]    out_chan;
    logic             out_sat;

    modport master (
        output out_valid, out_width, out_chan, out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_width, out_chan, out_sat,
        output out_ready
    );
endinterface

// File: rtl/pulse_meter.sv
// Multi-channel pulse-width meter: per-channel arm/count FSMs, one pending slot each,
// fixed-priority drain into a small result FIFO read out over valid/ready.
module pulse_meter #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    in_data,
    input  logic                   enable,
    input  logic                   pol_low,
    input  logic                   clr_drop,
    pulse_meter_if.master          out_if,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CHANNELS-1:0]    dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNT} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] w;
        logic [CW-1:0]    c;
        logic             s;
    } ent_t;

    logic [CHANNELS-1:0] act;
    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] sat_q, sat_d;
    logic [CHANNELS-1:0] cap;

    logic [CHANNELS-1:0] pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0]    pend_w_q [CHANNELS];
    logic [WIDTH-1:0]    pend_w_d [CHANNELS];
    logic [CHANNELS-1:0] pend_s_q, pend_s_d;
    logic [CHANNELS-1:0] drop;
    logic [CHANNELS-1:0] dropped_q, dropped_d;

    logic [CHANNELS-1:0] gnt;
    logic [CW-1:0]       gnt_idx;
    logic                push, pop, full;
    ent_t                push_ent;

    ent_t                mem_q [DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;

    assign act = in_data ^ {CHANNELS{pol_low}};

    // Per-channel FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sat_q <= sat_d;
        end
    end

    // Per-channel FSM: next state; dropping enable abandons any partial pulse
    always_comb begin
        sat_d = sat_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!enable) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
                sat_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        if (!act[i]) state_d[i] = S_ARMED;
                    end
                    S_ARMED: begin
                        if (act[i]) begin
                            state_d[i] = S_COUNT;
                            cnt_d[i]   = WIDTH'(1);
                            sat_d[i]   = 1'b0;
                        end
                    end
                    S_COUNT: begin
                        if (act[i]) begin
                            if (cnt_q[i] == CNT_MAX) sat_d[i] = 1'b1;
                            else                     cnt_d[i] = cnt_q[i] + WIDTH'(1);
                        end else begin
                            state_d[i] = S_ARMED;
                            cnt_d[i]   = '0;
                            sat_d[i]   = 1'b0;
                        end
                    end
                    default: state_d[i] = S_IDLE;
                endcase
            end
        end
    end

    // Per-channel FSM: outputs
    always_comb begin
        cap = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cap[i] = enable && (state_q[i] == S_COUNT) && !act[i];
        end
    end

    assign pop  = out_if.out_valid && out_if.out_ready;
    assign full = (fifo_count == (AW+1)'(DEPTH));

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        push    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!push && pend_vld_q[i] && (!full || pop)) begin
                push    = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = CW'(i);
            end
        end
    end

    always_comb begin
        push_ent = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt[i]) push_ent = '{w: pend_w_q[i], c: CW'(i), s: pend_s_q[i]};
        end
    end

    // A slot draining this cycle can take a new capture without losing it
    always_comb begin
        drop     = '0;
        pend_s_d = pend_s_q;
        for (int i = 0; i < CHANNELS; i++) begin
            pend_vld_d[i] = pend_vld_q[i] && !gnt[i];
            pend_w_d[i]   = pend_w_q[i];
            if (cap[i]) begin
                if (pend_vld_q[i] && !gnt[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pend_vld_d[i] = 1'b1;
                    pend_w_d[i]   = cnt_q[i];
                    pend_s_d[i]   = sat_q[i];
                end
            end
        end
        dropped_d = (clr_drop ? '0 : dropped_q) | drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= '0;
            pend_s_q   <= '0;
            dropped_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) pend_w_q[i] <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_s_q   <= pend_s_d;
            dropped_q  <= dropped_d;
            for (int i = 0; i < CHANNELS; i++) pend_w_q[i] <= pend_w_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_ent;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    assign fifo_count       = wr_ptr_q - rd_ptr_q;
    assign dropped          = dropped_q;
    assign out_if.out_valid = (fifo_count != '0);
    assign out_if.out_width = mem_q[rd_ptr_q[AW-1:0]].w;
    assign out_if.out_chan  = mem_q[rd_ptr_q[AW-1:0]].c;
    assign out_if.out_sat   = mem_q[rd_ptr_q[AW-1:0]].s;
endmodule

// File: tb/tb_pulse_meter.sv
// Directed stimulus for pulse_meter; expected results queued at stimulus time, checked by an output monitor.
module tb_pulse_meter;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [W-1:0]  w;
        logic [CW-1:0] c;
        logic          s;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] in_data;
    logic          enable, pol_low, clr_drop, out_ready;
    logic [2:0]    fifo_count;
    logic [CH-1:0] dropped;

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t exp_q[$];
    logic stall_prev = 1'b0;
    ent_t held;

    always #5 clk = ~clk;

    pulse_meter_if #(.WIDTH(W), .CW(CW)) ob ();
    assign ob.out_ready = out_ready;

    pulse_meter #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .enable     (enable),
        .pol_low    (pol_low),
        .clr_drop   (clr_drop),
        .out_if     (ob),
        .fifo_count (fifo_count),
        .dropped    (dropped)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ent(input int w, input int c, input bit s);
        exp_q.push_back('{w: W'(w), c: CW'(c), s: s});
    endtask

    // Monitor: checks each accepted head against the scoreboard and head stability while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (ob.out_valid && stall_prev) begin
                chk("stall_width", ob.out_width, held.w);
                chk("stall_chan", ob.out_chan, held.c);
            end
            if (ob.out_valid && ob.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_entry: got w=%0d c=%0d s=%0d expected none",
                             ob.out_width, ob.out_chan, ob.out_sat);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("out_width", ob.out_width, e.w);
                    chk("out_chan", ob.out_chan, e.c);
                    chk("out_sat", ob.out_sat, e.s);
                end
            end
            stall_prev = ob.out_valid && !ob.out_ready;
            held       = '{w: ob.out_width, c: ob.out_chan, s: ob.out_sat};
        end
    end

    initial begin
        rst_n = 1'b0; in_data = '0; enable = 1'b0; pol_low = 1'b0;
        clr_drop = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_valid", ob.out_valid, 0);
        chk("rst_width", ob.out_width, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_dropped", dropped, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic high pulse on ch2, 5 cycles, with latency check
        enable = 1'b1; tick();
        in_data[2] = 1'b1; repeat (5) tick();
        in_data[2] = 1'b0; expect_ent(5, 2, 1'b0);
        tick();
        chk("lat_T", ob.out_valid, 0);
        tick();
        chk("lat_T1", ob.out_valid, 1);
        repeat (3) tick();

        // Saturation then a short pulse
        in_data[0] = 1'b1; repeat (300) tick();
        in_data[0] = 1'b0; expect_ent(255, 0, 1'b1);
        repeat (3) tick();
        in_data[0] = 1'b1; repeat (3) tick();
        in_data[0] = 1'b0; expect_ent(3, 0, 1'b0);
        repeat (4) tick();

        // Pulse already active when enable rises: never measured
        enable = 1'b0; tick();
        in_data[1] = 1'b1; tick();
        enable = 1'b1; repeat (3) tick();
        in_data[1] = 1'b0; repeat (4) tick();
        chk("arm_no_entry", ob.out_valid, 0);

        // Enable dropped mid-pulse: discarded
        in_data[1] = 1'b1; repeat (3) tick();
        enable = 1'b0; tick();
        in_data[1] = 1'b0; tick();
        enable = 1'b1; repeat (3) tick();
        chk("abort_no_entry", ob.out_valid, 0);
        chk("abort_count", fifo_count, 0);

        // Low-pulse polarity on ch3, 4 cycles
        enable = 1'b0; tick();
        pol_low = 1'b1; in_data = 4'hF; tick();
        enable = 1'b1; tick();
        in_data[3] = 1'b0; repeat (4) tick();
        in_data[3] = 1'b1; expect_ent(4, 3, 1'b0);
        repeat (4) tick();
        enable = 1'b0; tick();
        pol_low = 1'b0; in_data = '0; tick();
        enable = 1'b1; tick();

        // All four channels end 6-cycle pulses on the same edge
        in_data = 4'hF; repeat (6) tick();
        in_data = '0;
        for (int c = 0; c < CH; c++) expect_ent(6, c, 1'b0);
        repeat (8) tick();
        chk("simul_dropped", dropped, 0);

        // Back-pressure: six 2-cycle pulses on ch3, sixth is dropped
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_data[3] = 1'b1; tick(); tick();
            in_data[3] = 1'b0; tick();
        end
        for (int k = 0; k < 5; k++) expect_ent(2, 3, 1'b0);
        chk("bp_count", fifo_count, 4);
        chk("bp_dropped", dropped, 4'b1000);
        tick();
        chk("bp_count_hold", fifo_count, 4);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_count_empty", fifo_count, 0);
        chk("bp_dropped_sticky", dropped, 4'b1000);
        clr_drop = 1'b1; tick();
        clr_drop = 1'b0;
        chk("clr_drop", dropped, 0);

        // Reset mid-stream with FIFO half full and a pulse counting
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_data[1] = 1'b1; tick(); tick();
            in_data[1] = 1'b0; tick();
        end
        tick();
        chk("pre_rst_count", fifo_count, 2);
        in_data[0] = 1'b1; tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ob.out_valid, 0);
        chk("mid_rst_width", ob.out_width, 0);
        chk("mid_rst_chan", ob.out_chan, 0);
        chk("mid_rst_sat", ob.out_sat, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_dropped", dropped, 0);
        in_data = '0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        in_data[2] = 1'b1; tick(); tick();
        in_data[2] = 1'b0; expect_ent(2, 2, 1'b0);
        repeat (6) tick();

        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_valid", ob.out_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_meter.md
# pulse_meter

Multi-channel successor to the single-channel pulse-width counter in the logic-analyzer datapath. Measures the width, in clock cycles, of active pulses on `CHANNELS` independent inputs, with selectable polarity, saturation flagging and arming on enable. Completed measurements are tagged with their channel number and queued in a small FIFO. The FIFO drains through a valid/ready interface toward the capture/readout logic.

## Interface
Parameters:
- `CHANNELS`, 4: number of monitored inputs (1..16).
- `WIDTH`, 8: width counter bits; max reportable width is 2^WIDTH-1.
- `DEPTH`, 4: result FIFO entries (power of two, ≥2).
- `CW`, derived: max(1, clog2(CHANNELS)), the channel-tag width.

Ports (direction, width, meaning):
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in CHANNELS: sampled inputs. Assumed already synchronous to `clk`.
- `enable` in 1: measurement enable.
- `pol_low` in 1: 0 measures high pulses, 1 measures low pulses. Change it only while `enable`=0.
- `clr_drop` in 1: single-cycle pulse that clears `dropped`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_width` out WIDTH: head pulse width.
- `out_chan` out CW: head channel index.
- `out_sat` out 1: head width saturated.
- `fifo_count` out clog2(DEPTH)+1: current FIFO occupancy.
- `dropped` out CHANNELS: sticky per-channel lost-measurement flags.

## Operation
- Active level: `act[i] = in_data[i] ^ pol_low`.
- Per-channel state is IDLE, ARMED, COUNT.
  - IDLE → ARMED when `enable`=1 and `act`=0.
  - ARMED → COUNT when `act`=1; the counter loads 1.
  - COUNT with `act`=1: counter increments, saturating at 2^WIDTH-1. The sat bit sets when an increment is attempted at max.
  - COUNT with `act`=0: capture {width, sat} into `pending[i]` and return to ARMED.
  - Any state → IDLE when `enable`=0. The counter and sat bit clear, and the partial pulse is discarded with no capture.
- A pulse already active when `enable` rises is never measured, because the channel must see inactive first.
- Pending slots: one per channel, with a valid bit.
  - A capture into an occupied slot is lost, and `dropped[i]` sets.
  - Exception: if the slot is transferring to the FIFO in that same cycle, the new capture is accepted.
- Arbiter: fixed priority, lowest index first. Moves at most one pending entry into the FIFO per cycle, and only when the FIFO is not full or a pop occurs in the same cycle.
- FIFO: push and pop in the same cycle are legal at any occupancy. A pop occurs on `out_valid && out_ready`.
- Output data is the FIFO head. It is stable while `out_valid`=1 and `out_ready`=0.
- `dropped`: `clr_drop` clears it, but a drop event in the same cycle takes priority and leaves that bit set.
- Pending entries and FIFO contents survive `enable`=0.

## Timing
- Reset (async assert, sync release) clears:
  - all channels to IDLE;
  - counters, pending valid bits and FIFO pointers;
  - `out_valid`=0, `out_width`=0, `out_chan`=0, `out_sat`=0, `fifo_count`=0, `dropped`=0.
- Reset asserted mid-operation discards everything immediately.
- Width is the number of rising edges at which `act`=1 was sampled. A 1-cycle pulse reports 1.
- Latency:
  - Edge T samples `act`=0 after a pulse: `pending` is valid after T.
  - FIFO push at T+1 if the channel wins arbitration.
  - `out_valid`=1 after T+1 if the FIFO was empty (2 cycles total).
  - Each losing channel waits one extra cycle per higher-priority entry.
- Back-to-back pulses on one channel (one inactive cycle between them) are both captured when the FIFO has space, because the slot drains the cycle after capture.
- `fifo_count` updates at the same edge as push/pop. Simultaneous push and pop leave it unchanged.

## Test plan
- **Basic high pulse:** `enable`=1, `pol_low`=0, `in_data[2]` high for 5 cycles → one entry {width=5, chan=2, sat=0}; `out_valid` rises 2 cycles after the falling sample.
- **Saturation:** `WIDTH`=8, `in_data[0]` high for 300 cycles → {width=255, sat=1}; a following 3-cycle pulse → {3, sat=0}.
- **Arming and abort:**
  - `in_data[1]` already high when `enable` rises → no entry.
  - `enable` dropped mid-pulse → no entry.
  - `pol_low`=1 with a 4-cycle low pulse → width 4.
- **Simultaneous capture:** all 4 channels end 6-cycle pulses on the same edge → FIFO outputs chan 0, 1, 2, 3 in order, each width 6; no drops.
- **Back-pressure and drops:**
  - `out_ready`=0, `DEPTH`=4, six 2-cycle pulses on ch3 separated by 1-cycle gaps → `fifo_count`=4, pending holds one, `dropped[3]`=1.
  - Then raise `out_ready` → exactly 5 entries drain with `out_width`/`out_chan` held stable while stalled.
  - `clr_drop` → `dropped`=0.
- **Reset mid-stream:** assert `rst_n`=0 with FIFO half full and a pulse counting → all outputs 0 immediately; after release a fresh 2-cycle pulse reports width 2.
